// File: rtl/scan_address_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scan_address_sequencer_pkg
// Purpose  : State encoding and default image widths shared between the
//            scan address sequencer and the system controller.
// Revision : 1.0 - initial release
// ============================================================================
package scan_address_sequencer_pkg;

    // Default image address widths
    localparam int c_BIP_W_DEFAULT = 12;
    localparam int c_WIP_W_DEFAULT = 16;
    localparam int c_CNT_W_DEFAULT = 16;

    // State encoding; the system controller decodes these same values
    localparam logic [1:0] c_ST_IDLE       = 2'b00;
    localparam logic [1:0] c_ST_SWEEP_BIT  = 2'b01;
    localparam logic [1:0] c_ST_SWEEP_WORD = 2'b10;
    localparam logic [1:0] c_ST_HOLD       = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE       = c_ST_IDLE,
        ST_SWEEP_BIT  = c_ST_SWEEP_BIT,
        ST_SWEEP_WORD = c_ST_SWEEP_WORD,
        ST_HOLD       = c_ST_HOLD
    } state_e;

endpackage
`default_nettype wire

// File: rtl/scan_address_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : scan_address_sequencer_if
// Purpose  : Controller <-> sequencer signal bundle for the PROG phase.
//            master = system controller side, slave = sequencer side.
// Revision : 1.0 - initial release
// ============================================================================
interface scan_address_sequencer_if #(
    parameter int BIP_W = 12,
    parameter int WIP_W = 16,
    parameter int CNT_W = 16
);
    logic             START;
    logic             STEP_EN;
    logic [BIP_W-1:0] A_0;
    logic [WIP_W-1:0] A_1;
    logic             RD_EN_0;
    logic             RD_EN_1;
    logic             BUSY;
    logic             SCAN_DONE;
    logic [CNT_W-1:0] SCAN_CNT;

    modport master (
        output START, STEP_EN,
        input  A_0, A_1, RD_EN_0, RD_EN_1, BUSY, SCAN_DONE, SCAN_CNT
    );

    modport slave (
        input  START, STEP_EN,
        output A_0, A_1, RD_EN_0, RD_EN_1, BUSY, SCAN_DONE, SCAN_CNT
    );
endinterface
`default_nettype wire

// File: rtl/scan_address_sequencer_sweep_counter.sv
`default_nettype none
// ============================================================================
// Module   : sweep_counter
// Purpose  : Saturating up-counter used for one image address. Clear wins
//            over enable; the count never wraps, at_max is the only exit cue.
// Revision : 1.0 - initial release
// ============================================================================
module sweep_counter #(
    parameter int WIDTH = 12
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clear,
    input  wire logic             i_enable,
    output logic      [WIDTH-1:0] o_count,
    output logic                  o_at_max
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             w_at_max;

    assign w_at_max = (count_q == {WIDTH{1'b1}});

    // Next count: clear, else saturating increment when enabled
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable && !w_at_max) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count  = count_q;
    assign o_at_max = w_at_max;
endmodule
`default_nettype wire

// File: rtl/scan_address_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : scan_address_sequencer
// Purpose  : PROG-phase responder. Sweeps the bit-image address, then the
//            word-image address, parks both at all-ones until START drops,
//            and counts completed sweeps.
// Revision : 1.0 - initial release
// ============================================================================
module scan_address_sequencer
    import scan_address_sequencer_pkg::*;
#(
    parameter int BIP_W = c_BIP_W_DEFAULT,
    parameter int WIP_W = c_WIP_W_DEFAULT,
    parameter int CNT_W = c_CNT_W_DEFAULT
) (
    input  wire logic               CLK,
    input  wire logic               CLR,
    scan_address_sequencer_if.slave bus
);
    state_e           state_q;
    state_e           state_d;
    logic             scan_done_q;
    logic             scan_done_d;
    logic [CNT_W-1:0] scan_cnt_q;
    logic [CNT_W-1:0] scan_cnt_d;

    logic             w_clear;
    logic             w_en_0;
    logic             w_en_1;
    logic             w_at_max_0;
    logic             w_at_max_1;
    logic [BIP_W-1:0] w_a_0;
    logic [WIP_W-1:0] w_a_1;

    sweep_counter #(.WIDTH(BIP_W)) u_bit_cnt (
        .clk      (CLK),
        .rst      (CLR),
        .i_clear  (w_clear),
        .i_enable (w_en_0),
        .o_count  (w_a_0),
        .o_at_max (w_at_max_0)
    );

    sweep_counter #(.WIDTH(WIP_W)) u_word_cnt (
        .clk      (CLK),
        .rst      (CLR),
        .i_clear  (w_clear),
        .i_enable (w_en_1),
        .o_count  (w_a_1),
        .o_at_max (w_at_max_1)
    );

    // Next-state, counter controls and completion bookkeeping. Losing START
    // always wins over STEP_EN so an aborted sweep never advances.
    always_comb begin
        state_d     = state_q;
        w_clear     = 1'b0;
        w_en_0      = 1'b0;
        w_en_1      = 1'b0;
        scan_done_d = 1'b0;
        scan_cnt_d  = scan_cnt_q;
        case (state_q)
            ST_IDLE: begin
                // Addresses held at zero so DONE compares cannot fire early
                w_clear = 1'b1;
                if (bus.START) begin
                    state_d = ST_SWEEP_BIT;
                end
            end
            ST_SWEEP_BIT: begin
                if (!bus.START) begin
                    state_d = ST_IDLE;
                    w_clear = 1'b1;
                end else if (bus.STEP_EN) begin
                    if (w_at_max_0) begin
                        state_d = ST_SWEEP_WORD;
                    end else begin
                        w_en_0 = 1'b1;
                    end
                end
            end
            ST_SWEEP_WORD: begin
                if (!bus.START) begin
                    state_d = ST_IDLE;
                    w_clear = 1'b1;
                end else if (bus.STEP_EN) begin
                    if (w_at_max_1) begin
                        state_d     = ST_HOLD;
                        scan_done_d = 1'b1;
                        scan_cnt_d  = scan_cnt_q + 1'b1;
                    end else begin
                        w_en_1 = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (!bus.START) begin
                    state_d = ST_IDLE;
                    w_clear = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                w_clear = 1'b1;
            end
        endcase
    end

    // State, completion pulse and scan counter registers
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q     <= ST_IDLE;
            scan_done_q <= 1'b0;
            scan_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            scan_done_q <= scan_done_d;
            scan_cnt_q  <= scan_cnt_d;
        end
    end

    assign bus.A_0       = w_a_0;
    assign bus.A_1       = w_a_1;
    assign bus.RD_EN_0   = (state_q == ST_SWEEP_BIT);
    assign bus.RD_EN_1   = (state_q == ST_SWEEP_WORD);
    assign bus.BUSY      = (state_q == ST_SWEEP_BIT) || (state_q == ST_SWEEP_WORD);
    assign bus.SCAN_DONE = scan_done_q;
    assign bus.SCAN_CNT  = scan_cnt_q;
endmodule
`default_nettype wire

// File: doc/scan_address_sequencer.md
# scan_address_sequencer

Program-phase responder for the PLC scan cycle. When the system controller raises START, the block sweeps the bit-image address A_0 from 0 to all-ones, then the word-image address A_1 from 0 to all-ones. It then parks both at all-ones, which makes the controller's DONE_0 and DONE_1 compare true and ends the PROG phase. When START drops, the block returns both addresses to 0 so the next PROG phase cannot complete spuriously.

## Interface
Parameters:
- BIP_W, 12, bit-image address width (A_0).
- WIP_W, 16, word-image address width (A_1).
- CNT_W, 16, width of the completed-scan counter.

Ports:
- CLK  in  1  single clock; all state changes on its rising edge.
- CLR  in  1  reset, synchronous, active-high.
- START  in  1  level from the system controller; high for the whole PROG phase.
- STEP_EN  in  1  memory/ALU ready; when low, addresses hold (stall).
- A_0  out  BIP_W  bit-image address; reset value 0.
- A_1  out  WIP_W  word-image address; reset value 0.
- RD_EN_0  out  1  high in SWEEP_BIT; reset value 0.
- RD_EN_1  out  1  high in SWEEP_WORD; reset value 0.
- BUSY  out  1  high in SWEEP_BIT or SWEEP_WORD; reset value 0.
- SCAN_DONE  out  1  one-cycle pulse on entry to HOLD; reset value 0.
- SCAN_CNT  out  CNT_W  number of completed sweeps, wraps modulo 2^CNT_W; reset value 0.

## Operation
- States: IDLE, SWEEP_BIT, SWEEP_WORD, HOLD. Reset state is IDLE.
- IDLE:
  - A_0 = A_1 = 0.
  - START=1 → SWEEP_BIT. Addresses are unchanged on that edge, so address 0 is presented for at least one cycle.
- SWEEP_BIT, with STEP_EN=1:
  - A_0 < max → A_0+1.
  - A_0 = max → SWEEP_WORD. A_0 stays at max.
  - STEP_EN=0 → no change.
- SWEEP_WORD, with STEP_EN=1:
  - A_1 < max → A_1+1.
  - A_1 = max → HOLD. SCAN_DONE=1 for that one cycle; SCAN_CNT+1.
  - STEP_EN=0 → no change.
- HOLD:
  - A_0 and A_1 stay at all-ones; STEP_EN is ignored.
  - START=0 → IDLE, and both addresses clear to 0 on the same edge.
- Abort: START=0 in SWEEP_BIT or SWEEP_WORD → IDLE, both addresses 0, no SCAN_DONE, SCAN_CNT unchanged. The abort has priority over STEP_EN.
- CLR has priority over everything. It may arrive mid-sweep; every output then returns to its reset value on the next edge.
- Arithmetic:
  - Address increments never wrap; the max compare is the only exit.
  - SCAN_CNT wraps from all-ones to 0.
- All outputs are registered or decoded from the state register. There is no combinational path from START or STEP_EN to any output.

## Timing
- START first sampled high at edge t → state is SWEEP_BIT after t, with A_0=0.
- STEP_EN held high: A_0 = max after t+(2^BIP_W − 1).
- SWEEP_WORD after t+2^BIP_W.
- A_1 = max after t+2^BIP_W+(2^WIP_W − 1).
- HOLD and SCAN_DONE after t+2^BIP_W+2^WIP_W. Defaults: 4096+65536 = 69632 cycles.
- Each STEP_EN=0 cycle adds exactly one cycle of latency.
- START sampled low at edge u (HOLD or abort) → A_0=A_1=0 after u.
- START re-asserted while in IDLE → new sweep exactly as above.
- START high at the same edge as the HOLD→IDLE check cannot happen: leaving HOLD requires START=0.

## Structure
- Shared package: state encoding constants (IDLE=2'b00, SWEEP_BIT=2'b01, SWEEP_WORD=2'b10, HOLD=2'b11) and the default BIP_W/WIP_W values, shared with the system controller.
- Sub-module sweep_counter, instantiated twice (widths BIP_W and WIP_W):
  - Inputs: clear, enable.
  - Behaviour: saturates at all-ones.
  - Output: at_max flag.
- The top holds the FSM, SCAN_CNT and the SCAN_DONE register.

## Test plan
All scenarios use BIP_W=4, WIP_W=4, CNT_W=4.
- Reset, then START=1 and STEP_EN=1 → A_0 steps 0..15 over 16 cycles; then A_1 steps 0..15; HOLD 32 cycles after START sampled; SCAN_DONE one pulse; SCAN_CNT=1.
- In HOLD, keep START=1 for 10 cycles → A_0=A_1=15, no further SCAN_DONE; drop START → next cycle both 0, state IDLE.
- STEP_EN toggled 1,0,1,0 during SWEEP_BIT → A_0 advances only on cycles with STEP_EN=1; HOLD reached 32 + (number of stall cycles) cycles after start.
- START dropped when A_1=5 → next cycle A_0=A_1=0, IDLE, no SCAN_DONE, SCAN_CNT unchanged.
- CLR asserted when A_0=7 → next cycle all outputs 0; with START still high, a sweep restarts from A_0=0 one cycle after CLR is released.
- 17 complete scans → SCAN_CNT wraps to 1; SCAN_DONE pulses exactly 17 times.
